// File: rtl/modport_apb_pkg.sv
// Shared address map, ID constant and decoded-target type for the APB register block.
package modport_apb_pkg;

  localparam logic [31:0] SCRATCH_BASE = 32'h0000_0000;
  localparam logic [31:0] ID_ADDR      = 32'h0000_0100;
  localparam logic [31:0] WAIT_ADDR    = 32'h0000_0104;
  localparam logic [31:0] WRCNT_ADDR   = 32'h0000_0108;
  localparam logic [31:0] ID_VALUE     = 32'h4150_4231;

  typedef enum logic [2:0] {
    T_SCRATCH,
    T_ID,
    T_WAIT,
    T_WRCNT,
    T_NONE
  } target_e;

endpackage

// File: rtl/modport_apb_decode.sv
// Combinational address decode: target register, scratch index and error flag.
module modport_apb_decode
  import modport_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  output target_e               target,
  output logic [IDX_W-1:0]      index,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // An address below the scratch base wraps to a huge word and so misses the scratch window.
  assign offset = paddr - ADDR_WIDTH'(SCRATCH_BASE);
  assign word   = offset >> 2;
  assign index  = word[IDX_W-1:0];

  always_comb begin
    target = T_NONE;
    if (word < ADDR_WIDTH'(NUM_REGS)) begin
      target = T_SCRATCH;
    end else if (paddr == ADDR_WIDTH'(ID_ADDR)) begin
      target = T_ID;
    end else if (paddr == ADDR_WIDTH'(WAIT_ADDR)) begin
      target = T_WAIT;
    end else if (paddr == ADDR_WIDTH'(WRCNT_ADDR)) begin
      target = T_WRCNT;
    end
  end

  always_comb begin
    err = (paddr[1:0] != 2'b00) || (target == T_NONE) ||
          (pwrite && ((target == T_ID) || (target == T_WRCNT)));
  end

endmodule

// File: rtl/modport_apb_slave.sv
// APB3 completer: scratch registers, ID, programmable wait states and a write counter.
module modport_apb_slave
  import modport_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  target_e          target;
  logic [IDX_W-1:0] index;
  logic             err;

  modport_apb_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .paddr (paddr),
    .pwrite(pwrite),
    .target(target),
    .index (index),
    .err   (err)
  );

  logic                  setup, access, commit;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            wait_q, wait_d;
  logic [3:0]            wait_reg_q, wait_reg_d;
  logic [DATA_WIDTH-1:0] wrcnt_q, wrcnt_d;
  logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] scratch_d [NUM_REGS];

  assign setup   = psel && !penable;
  assign access  = psel && penable;
  assign pready  = access && (cnt_q == wait_q);
  assign pslverr = pready && err;
  assign commit  = pready && pwrite && !err;

  always_comb begin
    cnt_d = cnt_q + 4'd1;
    if (!access || pready) begin
      cnt_d = 4'd0;
    end
    // Wait count is frozen per transfer so a WAIT write only affects later transfers.
    wait_d = setup ? wait_reg_q : wait_q;
  end

  always_comb begin
    scratch_d  = scratch_q;
    wait_reg_d = wait_reg_q;
    wrcnt_d    = wrcnt_q;
    if (commit) begin
      case (target)
        T_SCRATCH: scratch_d[index] = pwdata;
        T_WAIT:    wait_reg_d = pwdata[3:0];
        default:   ;
      endcase
      wrcnt_d = wrcnt_q + DATA_WIDTH'(1);
    end
  end

  always_comb begin
    prdata = '0;
    if (pready && !pwrite && !err) begin
      case (target)
        T_SCRATCH: prdata = scratch_q[index];
        T_ID:      prdata = DATA_WIDTH'(ID_VALUE);
        T_WAIT:    prdata = {{(DATA_WIDTH-4){1'b0}}, wait_reg_q};
        T_WRCNT:   prdata = wrcnt_q;
        default:   prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q      <= 4'd0;
      wait_q     <= 4'd0;
      wait_reg_q <= 4'd0;
      wrcnt_q    <= '0;
      scratch_q  <= '{default: '0};
    end else begin
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      wait_reg_q <= wait_reg_d;
      wrcnt_q    <= wrcnt_d;
      scratch_q  <= scratch_d;
    end
  end

endmodule

// File: tb/tb_modport_apb_slave.sv
// Self-checking bench for modport_apb_slave against a register-map reference model.
module tb_modport_apb_slave;

  localparam int NR = 16;
  localparam logic [31:0] ID_V = 32'h4150_4231;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  // Reference model state
  logic [31:0] m_scr [NR];
  logic [3:0]  m_wait;
  logic [31:0] m_wrcnt;

  modport_apb_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NR)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .paddr  (paddr),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_scr[i] = '0;
    m_wait  = '0;
    m_wrcnt = '0;
  endfunction

  // Expected response of one complete transfer, applying its effect to the model.
  function automatic void model_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er, output int wt);
    int kind; // 0 scratch, 1 ID, 2 WAIT, 3 WRCNT, 4 unmapped
    wt = int'(m_wait);
    rd = '0;
    if (a < 32'(4 * NR)) kind = 0;
    else if (a == 32'h100) kind = 1;
    else if (a == 32'h104) kind = 2;
    else if (a == 32'h108) kind = 3;
    else kind = 4;
    er = (a[1:0] != 2'b00) || (kind == 4) || (wr && (kind == 1 || kind == 3));
    if (!er) begin
      if (wr) begin
        if (kind == 0) m_scr[a / 4] = wd;
        if (kind == 2) m_wait = wd[3:0];
        m_wrcnt = m_wrcnt + 1;
      end else begin
        case (kind)
          0: rd = m_scr[a / 4];
          1: rd = ID_V;
          2: rd = {28'd0, m_wait};
          default: rd = m_wrcnt;
        endcase
      end
    end
  endfunction

  // Drives one full APB transfer; waits = access cycles seen with pready low (capped at 40).
  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int waits);
    @(posedge pclk); #1;
    paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge pclk);
    end
    rd = prdata;
    er = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    model_reset();
    @(negedge pclk);
    cmp_cnt++;
    if ({pready, pslverr} !== 2'b00 || prdata !== 32'd0) begin
      bad_cnt++;
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h, want 0/0/0",
               pready, pslverr, prdata);
    end
    @(posedge pclk); #1;
    preset = 1'b0;
    apb_xfer(32'h100, 1'b0, '0, rd, er, wt);
    model_xfer(32'h100, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== ID_V || er !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_id: got %h err=%b, want %h err=0", rd, er, ID_V);
    end
    apb_xfer(32'h108, 1'b0, '0, rd, er, wt);
    model_xfer(32'h108, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_wrcnt: got %h err=%b, want 0 err=0", rd, er);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    apb_xfer(32'h004, 1'b1, 32'hDEAD_BEEF, rd, er, wt);
    model_xfer(32'h004, 1'b1, 32'hDEAD_BEEF, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (wt !== 0 || er !== 1'b0) begin
      bad_cnt++;
      $display("FAIL zw_write: got waits=%0d err=%b, want 0/0", wt, er);
    end
    apb_xfer(32'h004, 1'b0, '0, rd, er, wt);
    model_xfer(32'h004, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'hDEAD_BEEF || wt !== 0) begin
      bad_cnt++;
      $display("FAIL zw_read: got %h waits=%0d, want deadbeef waits=0", rd, wt);
    end
    apb_xfer(32'h108, 1'b0, '0, rd, er, wt);
    model_xfer(32'h108, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'd1) begin
      bad_cnt++;
      $display("FAIL zw_wrcnt: got %h, want 1", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    apb_xfer(32'h104, 1'b1, 32'd3, rd, er, wt);
    model_xfer(32'h104, 1'b1, 32'd3, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (wt !== 0) begin
      bad_cnt++;
      $display("FAIL wait_write: got waits=%0d, want 0", wt);
    end
    apb_xfer(32'h000, 1'b0, '0, rd, er, wt);
    model_xfer(32'h000, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (wt !== 3 || rd !== e_rd || er !== 1'b0) begin
      bad_cnt++;
      $display("FAIL wait3_read: got waits=%0d data=%h err=%b, want 3 %h 0", wt, rd, er, e_rd);
    end
    apb_xfer(32'h104, 1'b1, 32'd0, rd, er, wt);
    model_xfer(32'h104, 1'b1, 32'd0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (wt !== 3) begin
      bad_cnt++;
      $display("FAIL wait_clear_write: got waits=%0d, want 3", wt);
    end
    apb_xfer(32'h004, 1'b0, '0, rd, er, wt);
    model_xfer(32'h004, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (wt !== 0 || rd !== e_rd) begin
      bad_cnt++;
      $display("FAIL wait0_read: got waits=%0d data=%h, want 0 %h", wt, rd, e_rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    logic [31:0] cnt_before;
    cnt_before = m_wrcnt;
    apb_xfer(32'h002, 1'b1, 32'h5555_AAAA, rd, er, wt);
    model_xfer(32'h002, 1'b1, 32'h5555_AAAA, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (er !== 1'b1) begin
      bad_cnt++;
      $display("FAIL err_misaligned: got pslverr=%b, want 1", er);
    end
    apb_xfer(32'h100, 1'b1, 32'h1111_2222, rd, er, wt);
    model_xfer(32'h100, 1'b1, 32'h1111_2222, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (er !== 1'b1) begin
      bad_cnt++;
      $display("FAIL err_ro_write: got pslverr=%b, want 1", er);
    end
    apb_xfer(32'h200, 1'b0, '0, rd, er, wt);
    model_xfer(32'h200, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      bad_cnt++;
      $display("FAIL err_unmapped: got pslverr=%b data=%h, want 1 0", er, rd);
    end
    apb_xfer(32'h100, 1'b0, '0, rd, er, wt);
    model_xfer(32'h100, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== ID_V) begin
      bad_cnt++;
      $display("FAIL err_id_kept: got %h, want %h", rd, ID_V);
    end
    apb_xfer(32'h000, 1'b0, '0, rd, er, wt);
    model_xfer(32'h000, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== e_rd) begin
      bad_cnt++;
      $display("FAIL err_scr0_kept: got %h, want %h", rd, e_rd);
    end
    apb_xfer(32'h108, 1'b0, '0, rd, er, wt);
    model_xfer(32'h108, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== cnt_before) begin
      bad_cnt++;
      $display("FAIL err_wrcnt: got %h, want %h", rd, cnt_before);
    end
  endtask

  task automatic test_last_index();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    apb_xfer(32'h03C, 1'b1, 32'h1234_5678, rd, er, wt);
    model_xfer(32'h03C, 1'b1, 32'h1234_5678, e_rd, e_er, e_wt);
    apb_xfer(32'h03C, 1'b0, '0, rd, er, wt);
    model_xfer(32'h03C, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      bad_cnt++;
      $display("FAIL last_read: got %h err=%b, want 12345678 0", rd, er);
    end
    apb_xfer(32'h040, 1'b1, 32'hFFFF_0000, rd, er, wt);
    model_xfer(32'h040, 1'b1, 32'hFFFF_0000, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (er !== 1'b1) begin
      bad_cnt++;
      $display("FAIL past_last: got pslverr=%b, want 1", er);
    end
    apb_xfer(32'h000, 1'b0, '0, rd, er, wt);
    model_xfer(32'h000, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== e_rd) begin
      bad_cnt++;
      $display("FAIL past_last_alias: got %h, want %h", rd, e_rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    apb_xfer(32'h104, 1'b1, 32'd2, rd, er, wt);
    model_xfer(32'h104, 1'b1, 32'd2, e_rd, e_er, e_wt);
    @(posedge pclk); #1;
    paddr = 32'h00C; pwrite = 1'b1; pwdata = 32'hA5A5_0F0F; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    cmp_cnt++;
    if (pready !== 1'b0) begin
      bad_cnt++;
      $display("FAIL abort_pready: got %b, want 0", pready);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    apb_xfer(32'h00C, 1'b0, '0, rd, er, wt);
    model_xfer(32'h00C, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== e_rd || wt !== e_wt) begin
      bad_cnt++;
      $display("FAIL abort_nocommit: got %h waits=%0d, want %h waits=%0d", rd, wt, e_rd, e_wt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, e_rd;
    logic er, e_er;
    int wt, e_wt;
    apb_xfer(32'h008, 1'b1, 32'h0BAD_F00D, rd, er, wt);
    model_xfer(32'h008, 1'b1, 32'h0BAD_F00D, e_rd, e_er, e_wt);
    apb_xfer(32'h104, 1'b1, 32'd5, rd, er, wt);
    model_xfer(32'h104, 1'b1, 32'd5, e_rd, e_er, e_wt);
    @(posedge pclk); #1;
    paddr = 32'h008; pwrite = 1'b1; pwdata = 32'hCAFE_BABE; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge pclk);
    cmp_cnt++;
    if (pready !== 1'b0) begin
      bad_cnt++;
      $display("FAIL midrst_pready: got %b, want 0", pready);
    end
    apb_xfer(32'h008, 1'b0, '0, rd, er, wt);
    model_xfer(32'h008, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'd0 || wt !== 0) begin
      bad_cnt++;
      $display("FAIL midrst_scr: got %h waits=%0d, want 0 waits=0", rd, wt);
    end
    apb_xfer(32'h104, 1'b0, '0, rd, er, wt);
    model_xfer(32'h104, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'd0) begin
      bad_cnt++;
      $display("FAIL midrst_wait: got %h, want 0", rd);
    end
    apb_xfer(32'h108, 1'b0, '0, rd, er, wt);
    model_xfer(32'h108, 1'b0, '0, e_rd, e_er, e_wt);
    cmp_cnt++;
    if (rd !== 32'd0) begin
      bad_cnt++;
      $display("FAIL midrst_wrcnt: got %h, want 0", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, a, wd;
    logic er, e_er, wr;
    int wt, e_wt;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = 32'($urandom_range(0, NR - 1)) * 4;
        4: a = 32'h100;
        5: a = 32'h104;
        6: a = 32'h108;
        default: begin
          case ($urandom_range(0, 2))
            0: a = 32'($urandom_range(0, NR - 1)) * 4 + 32'($urandom_range(1, 3));
            1: a = 32'h10C;
            default: a = 32'h200 + 32'($urandom_range(0, 63)) * 4;
          endcase
        end
      endcase
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 32'h104) wd[3:0] = 4'($urandom_range(0, 4));
      apb_xfer(a, wr, wd, rd, er, wt);
      model_xfer(a, wr, wd, e_rd, e_er, e_wt);
      cmp_cnt++;
      if (rd !== e_rd || er !== e_er || wt !== e_wt) begin
        bad_cnt++;
        $display("FAIL rand_%0d a=%h wr=%b: got data=%h err=%b waits=%0d, want %h %b %0d",
                 n, a, wr, rd, er, wt, e_rd, e_er, e_wt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_last_index();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/modport_apb_slave.md
Name: modport_apb_slave

Overview:
- APB3 (AMBA 3 APB v1.0) completer implementing a small memory-mapped register block.
- Connects to the slave side of the team's APB interface: paddr, psel, penable, pwrite and pwdata in; pready, prdata and pslverr out.
- Provides scratch registers, a read-only ID register, a programmable wait-state register and a write counter.
- Exercises the full handshake, including the pready wait loop and pslverr.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata and prdata. Fixed at 32 for this block.
- NUM_REGS, 16, number of scratch registers (power of 2, at most 64).

Ports:
- pclk  in  1  APB clock; all state updates on its rising edge.
- preset  in  1  reset, synchronous, active-high.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  1  slave select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer completes on an edge where psel&penable&pready.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  error response.

Behaviour:
- Clock and reset: one clock pclk. Reset preset is synchronous and active-high.
- Register map (word-aligned, byte offsets):
  - 0x000 to 0x000+4*(NUM_REGS-1): SCRATCH[i], read/write, reset 0.
  - 0x100: ID, read-only, returns 0x4150_4231.
  - 0x104: WAIT, read/write, bits [3:0] = wait states; upper bits read 0. Reset 0.
  - 0x108: WRCNT, read-only, 32-bit count of committed writes to any RW register. Wraps 0xFFFF_FFFF to 0. Reset 0.
- Phases:
  - Setup = psel & !penable.
  - Access = psel & penable.
  - Idle = !psel.
- Wait latching: on each setup-phase edge, latch wait_q <= WAIT[3:0]. A WAIT write therefore takes effect from the next transfer.
- Access counter cnt (4 bits):
  - Cleared in idle/setup and on the completing edge.
  - Otherwise incremented each access edge.
- pready = access & (cnt == wait_q). It is combinational from registered state.
  - WAIT=0: zero-wait transfer, pready high in the first access cycle.
  - WAIT=N: pready rises in the (N+1)th access cycle.
- Error (combinational, address decode): err = paddr[1:0]!=0, or unmapped address, or (pwrite & RO target).
- pslverr = pready & err; otherwise 0.
- prdata:
  - When pready & !pwrite & !err: mux of the addressed register.
  - Otherwise 0.
- Write commit: at the edge where access & pready & pwrite & !err.
  - Update the target register. Full 32-bit write; there is no pstrb.
  - WRCNT += 1.
- Errored writes change no state and do not increment WRCNT.
- Reads have no side effects.
- paddr, pwrite and pwdata are assumed stable from setup through completion. The design samples them only in the access phase.
- Reset outputs: pready=0, prdata=0, pslverr=0.
- Reset asserted mid-transfer:
  - Aborts the transfer with no commit.
  - Clears cnt, wait_q, registers and WRCNT.
- psel dropped before pready: counter clears, no commit.

Decomposition:
- Shared package modport_apb_pkg holds:
  - Address offset constants (SCRATCH_BASE, ID_ADDR, WAIT_ADDR, WRCNT_ADDR).
  - ID_VALUE.
  - A typedef for the decoded target enum (T_SCRATCH, T_ID, T_WAIT, T_WRCNT, T_NONE).
- Natural sub-module: modport_apb_decode.
  - Combinational paddr/pwrite to target, index and err.
- The top module holds the handshake counter, registers and read mux.

Test Plan:
- Reset: hold preset for 2 cycles -> pready=0, pslverr=0, prdata=0; read 0x100 -> 0x4150_4231; read 0x108 -> 0.
- Zero-wait RW: write 0x004 <= 0xDEAD_BEEF -> pready in first access cycle, pslverr=0; read 0x004 -> 0xDEAD_BEEF; WRCNT reads 1.
- Wait states: write 0x104 <= 3, then read 0x000 -> pready low for 3 access cycles, high on the 4th; data correct. Write 0x104 <= 0 -> the next transfer is zero-wait.
- Errors:
  - Write 0x002 -> pslverr=1, no change.
  - Write 0x100 -> pslverr=1, ID unchanged.
  - Read 0x200 -> pslverr=1, prdata=0.
  - WRCNT unchanged across all three.
- Wrap/last index: write SCRATCH[NUM_REGS-1] at 0x03C <= 0x1234_5678 -> read back correct; 0x040 -> pslverr=1.
- Reset mid-transfer: WAIT=5, start a write to 0x008, assert preset in the 2nd access cycle -> 0x008 reads 0, WAIT reads 0.
